// File: rtl/layer_encoder.sv
// layer_encoder
//   Pixel-layer priority encoder with frame-level collision detect and a
//   day/night palette flash sequencer.
//
//   Parameters
//     FLASH_FRAMES  frames the invert output toggles during a flash (1..255)
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     pix_en                        pixel strobe; pipeline advances only when 1
//     frame_start                   one-cycle start-of-frame pulse
//     hit[3:0]                      per-layer coverage (0 bg, 1 obstacle,
//                                   2 dino, 3 score)
//     de_in, hsync_in, vsync_in     timing aligned with hit
//     invert_req                    request a flash sequence
//     is_colored, layer[1:0]        winning layer, 2 strobes after hit
//     de_out, hsync_out, vsync_out  timing delayed to match is_colored/layer
//     invert                        palette inversion for the colour decoder
//     collision                     dino/obstacle overlap in previous frame
//     flashing                      flash sequence in progress
module layer_encoder #(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       frame_start,
    input  logic [3:0] hit,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       invert_req,
    output logic       is_colored,
    output logic [1:0] layer,
    output logic       de_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       invert,
    output logic       collision,
    output logic       flashing
);

    localparam logic [7:0] CNT_INIT = 8'(FLASH_FRAMES - 1);

    typedef enum logic {
        IDLE,
        FLASH
    } state_t;

    // Stage 1 registers
    logic [3:0] hit_s1_q, hit_s1_d;
    logic       de_s1_q, de_s1_d;
    logic       hs_s1_q, hs_s1_d;
    logic       vs_s1_q, vs_s1_d;

    // Stage 2 (output) registers
    logic       is_colored_q, is_colored_d;
    logic [1:0] layer_q, layer_d;
    logic       de_out_q, de_out_d;
    logic       hsync_out_q, hsync_out_d;
    logic       vsync_out_q, vsync_out_d;

    // Collision tracking
    logic       coll_acc_q, coll_acc_d;
    logic       collision_q, collision_d;
    logic       detect;

    // Flash sequencer
    state_t     state_q, state_d;
    logic       req_pend_q, req_pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic       invert_q, invert_d;
    logic       base_q, base_d;
    logic       flashing_q, flashing_d;

    // Pixel pipeline
    always_comb begin
        hit_s1_d     = hit_s1_q;
        de_s1_d      = de_s1_q;
        hs_s1_d      = hs_s1_q;
        vs_s1_d      = vs_s1_q;
        is_colored_d = is_colored_q;
        layer_d      = layer_q;
        de_out_d     = de_out_q;
        hsync_out_d  = hsync_out_q;
        vsync_out_d  = vsync_out_q;
        if (pix_en) begin
            hit_s1_d    = hit;
            de_s1_d     = de_in;
            hs_s1_d     = hsync_in;
            vs_s1_d     = vsync_in;
            de_out_d    = de_s1_q;
            hsync_out_d = hs_s1_q;
            vsync_out_d = vs_s1_q;
            // Highest set layer wins; blanked or empty pixels report layer 0
            is_colored_d = de_s1_q && (hit_s1_q != 4'b0000);
            if (!de_s1_q)         layer_d = 2'd0;
            else if (hit_s1_q[3]) layer_d = 2'd3;
            else if (hit_s1_q[2]) layer_d = 2'd2;
            else if (hit_s1_q[1]) layer_d = 2'd1;
            else                  layer_d = 2'd0;
        end
    end

    // Collision: a detect on the frame_start cycle belongs to the closing frame
    assign detect = pix_en && de_in && hit[1] && hit[2];

    always_comb begin
        coll_acc_d  = coll_acc_q | detect;
        collision_d = collision_q;
        if (frame_start) begin
            collision_d = coll_acc_q | detect;
            coll_acc_d  = 1'b0;
        end
    end

    // Flash sequencer next state
    always_comb begin
        state_d    = state_q;
        req_pend_d = req_pend_q;
        cnt_d      = cnt_q;
        invert_d   = invert_q;
        base_d     = base_q;
        if (state_q == IDLE) begin
            if (frame_start && (req_pend_q || invert_req)) begin
                state_d    = FLASH;
                base_d     = invert_q;
                req_pend_d = 1'b0;
                cnt_d      = CNT_INIT;
                invert_d   = ~invert_q;
            end else if (invert_req) begin
                req_pend_d = 1'b1;
            end
        end else if (frame_start) begin
            if (cnt_q != 8'd0) begin
                invert_d = ~invert_q;
                cnt_d    = cnt_q - 8'd1;
            end else begin
                // Final frame: force the complement of the starting value
                invert_d = ~base_q;
                state_d  = IDLE;
            end
        end
        flashing_d = (state_d == FLASH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_s1_q     <= '0;
            de_s1_q      <= 1'b0;
            hs_s1_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            is_colored_q <= 1'b0;
            layer_q      <= '0;
            de_out_q     <= 1'b0;
            hsync_out_q  <= 1'b0;
            vsync_out_q  <= 1'b0;
            coll_acc_q   <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            hit_s1_q     <= hit_s1_d;
            de_s1_q      <= de_s1_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            is_colored_q <= is_colored_d;
            layer_q      <= layer_d;
            de_out_q     <= de_out_d;
            hsync_out_q  <= hsync_out_d;
            vsync_out_q  <= vsync_out_d;
            coll_acc_q   <= coll_acc_d;
            collision_q  <= collision_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_pend_q <= 1'b0;
            cnt_q      <= '0;
            invert_q   <= 1'b0;
            base_q     <= 1'b0;
            flashing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pend_q <= req_pend_d;
            cnt_q      <= cnt_d;
            invert_q   <= invert_d;
            base_q     <= base_d;
            flashing_q <= flashing_d;
        end
    end

    assign is_colored = is_colored_q;
    assign layer      = layer_q;
    assign de_out     = de_out_q;
    assign hsync_out  = hsync_out_q;
    assign vsync_out  = vsync_out_q;
    assign invert     = invert_q;
    assign collision  = collision_q;
    assign flashing   = flashing_q;

endmodule

// File: tb/tb_layer_encoder.sv
module tb_layer_encoder;

    logic       clk = 1'b0;
    logic       rst, pix_en, frame_start, de_in, hsync_in, vsync_in, invert_req;
    logic [3:0] hit;
    logic       is_colored, de_out, hsync_out, vsync_out, invert, collision, flashing;
    logic [1:0] layer;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    layer_encoder #(.FLASH_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .frame_start(frame_start),
        .hit(hit), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .invert_req(invert_req), .is_colored(is_colored), .layer(layer),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .invert(invert), .collision(collision), .flashing(flashing)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled there too.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b1; frame_start = 1'b0; hit = 4'b1111;
        de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; invert_req = 1'b0;
        tick(); tick();
        check("rst_col", is_colored, 0);
        check("rst_layer", layer, 0);
        check("rst_de", de_out, 0);
        check("rst_hs", hsync_out, 0);
        check("rst_vs", vsync_out, 0);
        check("rst_inv", invert, 0);
        check("rst_flash", flashing, 0);
        check("rst_coll", collision, 0);

        // Basic priority encoding, 2-strobe latency
        rst = 1'b0; hit = 4'b0110; hsync_in = 1'b1; vsync_in = 1'b1;
        tick();
        check("lat1_col", is_colored, 0);
        hit = 4'b0001; hsync_in = 1'b0; vsync_in = 1'b0;
        tick();
        check("p0110_col", is_colored, 1);
        check("p0110_layer", layer, 2);
        check("p0110_hs", hsync_out, 1);
        check("p0110_vs", vsync_out, 1);
        check("p0110_de", de_out, 1);
        hit = 4'b0000;
        tick();
        check("p0001_col", is_colored, 1);
        check("p0001_layer", layer, 0);
        check("p0001_hs", hsync_out, 0);
        tick();
        check("p0000_col", is_colored, 0);
        check("p0000_layer", layer, 0);
        check("coll_midframe", collision, 0);

        // Overlap above was in frame N
        fs_pulse();
        check("coll_n1", collision, 1);
        hit = 4'b0001;
        repeat (5) tick();
        check("coll_n1_hold", collision, 1);
        fs_pulse();
        check("coll_n2_clear", collision, 0);

        // Blanked overlap: not colored, no collision
        de_in = 1'b0; hit = 4'b1111;
        tick(); tick();
        check("blank_col", is_colored, 0);
        check("blank_layer", layer, 0);
        check("blank_de", de_out, 0);
        de_in = 1'b1; hit = 4'b0000;
        fs_pulse();
        check("blank_coll", collision, 0);

        // Overlap coinciding with frame_start closes the old frame
        hit = 4'b0110; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; hit = 4'b0000;
        check("coll_same_cycle", collision, 1);
        tick(); tick();
        check("coll_same_hold", collision, 1);
        fs_pulse();
        check("coll_same_next", collision, 0);

        // Sparse strobes: every 4th cycle
        hit = 4'b0000; hsync_in = 1'b0; tick(); tick();
        hit = 4'b1000; hsync_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix_en = (i % 4 == 0);
            if (i > 0) begin
                hit = 4'b0000; hsync_in = 1'b0;
            end
            tick();
            check("sparse_layer", layer, (i >= 4) ? 3 : 0);
            check("sparse_col", is_colored, (i >= 4) ? 1 : 0);
            check("sparse_hs", hsync_out, (i >= 4) ? 1 : 0);
        end
        pix_en = 1'b1;

        // Flash sequence, FLASH_FRAMES=3
        invert_req = 1'b1; tick(); invert_req = 1'b0;
        check("fl_pend_inv", invert, 0);
        check("fl_pend_flash", flashing, 0);
        tick();
        fs_pulse();
        check("fl1_inv", invert, 1);
        check("fl1_flash", flashing, 1);
        tick();
        invert_req = 1'b1; tick(); invert_req = 1'b0;
        check("fl1_hold", invert, 1);
        fs_pulse();
        check("fl2_inv", invert, 0);
        check("fl2_flash", flashing, 1);
        fs_pulse();
        check("fl3_inv", invert, 1);
        check("fl3_flash", flashing, 1);
        fs_pulse();
        check("fl_end_inv", invert, 1);
        check("fl_end_flash", flashing, 0);
        fs_pulse();
        check("fl_nodup_inv", invert, 1);
        check("fl_nodup_flash", flashing, 0);

        // Reset mid-flash with invert=1
        invert_req = 1'b1; frame_start = 1'b1; tick();
        invert_req = 1'b0; frame_start = 1'b0;
        check("fl_b1_inv", invert, 0);
        fs_pulse();
        check("fl_b2_inv", invert, 1);
        check("fl_b2_flash", flashing, 1);
        hit = 4'b1000; hsync_in = 1'b1; vsync_in = 1'b1;
        tick(); tick();
        check("pre_rst_col", is_colored, 1);
        rst = 1'b1; invert_req = 1'b1; frame_start = 1'b1;
        tick();
        check("mrst_inv", invert, 0);
        check("mrst_flash", flashing, 0);
        check("mrst_col", is_colored, 0);
        check("mrst_layer", layer, 0);
        check("mrst_de", de_out, 0);
        check("mrst_hs", hsync_out, 0);
        check("mrst_vs", vsync_out, 0);
        rst = 1'b0; invert_req = 1'b0; frame_start = 1'b0; hit = 4'b0000;
        tick();
        fs_pulse();
        check("post_rst_flash", flashing, 0);
        check("post_rst_inv", invert, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
